// File: rtl/axi_timer.sv
// axi_timer: AXI4-Lite memory-mapped 64-bit machine timer.
// Register map, decoded from addr[3:2] only:
//   0 = mtime_lo, 1 = mtime_hi (shadow captured when mtime_lo is read),
//   2 = mtimecmp_lo, 3 = mtimecmp_hi.
// Optional feature macro: AXI_TIMER_CMP_EN. When defined, the mtimecmp
// registers and the timer_irq compare logic are built. When undefined, the
// mtimecmp offsets read as 0, writes to them are acknowledged and dropped,
// and timer_irq is tied low.
module axi_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        timer_irq
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic [15:0] presc_cnt;
    logic [63:0] mtime;
    logic [31:0] shadow;
    logic [31:0] rdata_q;
    logic [31:0] rd_val;
    logic [1:0]  aw_sel_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        do_write;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        ar_hs, aw_hs, w_hs;
    logic        unused_addr_bits;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rdata   = rdata_q;
    assign awready = (w_state == W_IDLE) || (w_state == W_GOT_W);
    assign wready  = (w_state == W_IDLE) || (w_state == W_GOT_AW);
    assign bvalid  = (w_state == W_RESP);
    assign bresp   = 2'b00;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign unused_addr_bits = ^{araddr[31:4], araddr[1:0], awaddr[31:4], awaddr[1:0]};

`ifdef AXI_TIMER_CMP_EN
    logic [63:0] mtimecmp;
    logic        irq_q;

    // Compare register write path; reset leaves the interrupt disarmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (do_write && wr_sel == 2'd2) begin
            mtimecmp[31:0] <= apply_strb(mtimecmp[31:0], wr_data, wr_strb);
        end else if (do_write && wr_sel == 2'd3) begin
            mtimecmp[63:32] <= apply_strb(mtimecmp[63:32], wr_data, wr_strb);
        end
    end

    // Registered level interrupt, one cycle behind the compared values.
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= (mtime >= mtimecmp);
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    // Read register select for the address currently on the AR channel.
    always_comb begin
        rd_val = 32'h0;
        case (araddr[3:2])
            2'd0: rd_val = mtime[31:0];
            2'd1: rd_val = shadow;
`ifdef AXI_TIMER_CMP_EN
            2'd2: rd_val = mtimecmp[31:0];
            2'd3: rd_val = mtimecmp[63:32];
`endif
            default: rd_val = 32'h0;
        endcase
    end

    // Read state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read next-state: accept one address, hold data until it is taken.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Capture read data and, on an mtime_lo read, the matching upper half.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            shadow  <= 32'h0;
        end else if (ar_hs) begin
            rdata_q <= rd_val;
            if (araddr[3:2] == 2'd0) shadow <= mtime[63:32];
        end
    end

    // Write state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write next-state and the write strobe; a half already latched is taken
    // from its holding register, the other half straight from the bus.
    always_comb begin
        w_next   = w_state;
        do_write = 1'b0;
        wr_sel   = awaddr[3:2];
        wr_data  = wdata;
        wr_strb  = wstrb;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    do_write = 1'b1;
                    w_next   = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_GOT_AW;
                end else if (w_hs) begin
                    w_next = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                wr_sel = aw_sel_q;
                if (w_hs) begin
                    do_write = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_GOT_W: begin
                wr_data = wdata_q;
                wr_strb = wstrb_q;
                if (aw_hs) begin
                    do_write = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Hold whichever write half arrives first.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_sel_q <= 2'd0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
        end else begin
            if (aw_hs) aw_sel_q <= awaddr[3:2];
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    // mtime and prescaler; a bus write beats the increment and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= 64'h0;
            presc_cnt <= 16'h0;
        end else if (do_write && wr_sel == 2'd0) begin
            mtime[31:0] <= apply_strb(mtime[31:0], wr_data, wr_strb);
            presc_cnt   <= 16'h0;
        end else if (do_write && wr_sel == 2'd1) begin
            mtime[63:32] <= apply_strb(mtime[63:32], wr_data, wr_strb);
            presc_cnt    <= 16'h0;
        end else if (presc_cnt == PRESCALE_LAST) begin
            mtime     <= mtime + 64'd1;
            presc_cnt <= 16'h0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_timer.sv
// tb_axi_timer: directed self-checking bench for axi_timer.
// Two instances: dut (PRESCALE=1) for the bus/compare scenarios and dut_4
// (PRESCALE=4) for prescaler timing. Expectations follow AXI_TIMER_CMP_EN.
module tb_axi_timer;

`ifdef AXI_TIMER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        timer_irq;

    logic        rst_4;
    logic [31:0] araddr_4;
    logic        arvalid_4;
    logic        arready_4;
    logic [31:0] rdata_4;
    logic        rvalid_4;
    logic        rready_4;
    logic [31:0] awaddr_4;
    logic        awvalid_4;
    logic        awready_4;
    logic [31:0] wdata_4;
    logic [3:0]  wstrb_4;
    logic        wvalid_4;
    logic        wready_4;
    logic [1:0]  bresp_4;
    logic        bvalid_4;
    logic        bready_4;
    logic        timer_irq_4;

    int checks = 0;
    int errors = 0;

    axi_timer #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .timer_irq(timer_irq)
    );

    axi_timer #(.PRESCALE(4)) dut_4 (
        .clk(clk), .rst(rst_4),
        .araddr(araddr_4), .arvalid(arvalid_4), .arready(arready_4),
        .rdata(rdata_4), .rvalid(rvalid_4), .rready(rready_4),
        .awaddr(awaddr_4), .awvalid(awvalid_4), .awready(awready_4),
        .wdata(wdata_4), .wstrb(wstrb_4), .wvalid(wvalid_4), .wready(wready_4),
        .bresp(bresp_4), .bvalid(bvalid_4), .bready(bready_4),
        .timer_irq(timer_irq_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single write with AW and W presented together; ends after the B handshake.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick; n++; end
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL write_timeout: bvalid=%0b required 1 at addr %h", bvalid, a);
        end
        tick;
    endtask

    // Single read; ends after the R handshake.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick; n++; end
        tick;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin tick; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("[TB] FAIL read_timeout: rvalid=%0b required 1 at addr %h", rvalid, a);
        end
        d = rdata;
        tick;
        rready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            errors++; $display("[TB] FAIL reset_readies: got %b required 111", {arready, awready, wready});
        end
        checks++;
        if ({rvalid, bvalid, bresp, timer_irq} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %b required 00000", {rvalid, bvalid, bresp, timer_irq});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h required 0", rdata);
        end
    endtask

    task automatic test_read_hold;
        logic [31:0] held;
        logic [31:0] d;
        repeat (10) tick;
        araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
        tick;
        arvalid = 1'b0;
        held = rdata;
        checks++;
        if (rvalid !== 1'b1 || rdata < 32'd9 || rdata > 32'd11) begin
            errors++; $display("[TB] FAIL first_read: rvalid=%0b rdata=%0d required 1 and 9..11", rvalid, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL read_hold_%0d: rvalid=%0b rdata=%h arready=%0b required 1 %h 0", i, rvalid, rdata, arready, held);
            end
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("[TB] FAIL read_release: rvalid=%0b arready=%0b required 0 1", rvalid, arready);
        end
        axi_read(32'h8, d);
        checks++;
        if (d !== (CMP_EN ? 32'hFFFF_FFFF : 32'h0)) begin
            errors++; $display("[TB] FAIL cmp_reset_read: got %h required %h", d, CMP_EN ? 32'hFFFF_FFFF : 32'h0);
        end
    endtask

    task automatic test_wrap_shadow;
        logic [31:0] lo;
        logic [31:0] hi;
        axi_write(32'h4, 32'h0, 4'hF);
        axi_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        repeat (5) tick;
        axi_read(32'h0, lo);
        axi_read(32'h4, hi);
        checks++;
        if (hi !== 32'h1 || lo > 32'd16) begin
            errors++; $display("[TB] FAIL lo_carry: hi=%h lo=%h required hi=1 lo<=16", hi, lo);
        end
        axi_write(32'h4, 32'h0, 4'hF);
        axi_write(32'hF000_0000, 32'hFFFF_FFF0, 4'hF);
        axi_read(32'h0, lo);
        repeat (30) tick;
        axi_read(32'h4, hi);
        checks++;
        if (lo < 32'hFFFF_FFF0 || hi !== 32'h0) begin
            errors++; $display("[TB] FAIL shadow_hold: lo=%h hi=%h required lo>=fffffff0 hi=0", lo, hi);
        end
        axi_read(32'h3, lo);
        axi_read(32'h7, hi);
        checks++;
        if (hi !== 32'h1 || lo > 32'd64) begin
            errors++; $display("[TB] FAIL shadow_update: hi=%h lo=%h required hi=1 lo<=64", hi, lo);
        end
    endtask

    task automatic test_w_before_aw;
        int pulses;
        logic [31:0] d;
        bready = 1'b1;
        wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL got_w_state: wready=%0b awready=%0b bvalid=%0b required 0 1 0", wready, awready, bvalid);
        end
        tick;
        awaddr = 32'h8; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid === 1'b1) begin
                pulses++;
                checks++;
                if (bresp !== 2'b00) begin
                    errors++; $display("[TB] FAIL bresp: got %b required 00", bresp);
                end
            end
            tick;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("[TB] FAIL bvalid_pulses: got %0d required 1", pulses);
        end
        axi_read(32'h8, d);
        checks++;
        if (d !== (CMP_EN ? 32'hFFFF_5678 : 32'h0)) begin
            errors++; $display("[TB] FAIL strobe_write: got %h required %h", d, CMP_EN ? 32'hFFFF_5678 : 32'h0);
        end
        axi_read(32'hC, d);
        checks++;
        if (d !== (CMP_EN ? 32'hFFFF_FFFF : 32'h0)) begin
            errors++; $display("[TB] FAIL cmp_hi_untouched: got %h required %h", d, CMP_EN ? 32'hFFFF_FFFF : 32'h0);
        end
    endtask

    task automatic test_irq;
        axi_write(32'hC, 32'h0, 4'hF);
        axi_write(32'h8, 32'd20, 4'hF);
        axi_write(32'h4, 32'h0, 4'hF);
        axi_write(32'h0, 32'h0, 4'hF);
        repeat (19) tick;
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("[TB] FAIL irq_before: got %0b required 0", timer_irq);
        end
        tick;
        checks++;
        if (timer_irq !== CMP_EN) begin
            errors++; $display("[TB] FAIL irq_rise: got %0b required %0b", timer_irq, CMP_EN);
        end
        axi_write(32'hC, 32'h1, 4'hF);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("[TB] FAIL irq_fall: got %0b required 0", timer_irq);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
        awaddr = 32'h4; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        tick;
        arvalid = 1'b0; awvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_setup: rvalid=%0b awready=%0b wready=%0b required 1 0 1", rvalid, awready, wready);
        end
        rst = 1'b1;
        wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        rst = 1'b0; wvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_abort: rvalid=%0b bvalid=%0b required 0 0", rvalid, bvalid);
        end
        checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            errors++; $display("[TB] FAIL mid_readies: got %b required 111", {arready, awready, wready});
        end
        axi_read(32'h0, d);
        axi_read(32'h4, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL mid_no_write: mtime_hi=%h required 0", d);
        end
    endtask

    task automatic test_prescale4;
        rst_4 = 1'b1;
        tick; tick;
        rst_4 = 1'b0;
        araddr_4 = 32'h0; arvalid_4 = 1'b1; rready_4 = 1'b1; bready_4 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick;
            checks++;
            if (rvalid_4 !== 1'b1 || rdata_4 !== 32'(j / 2)) begin
                errors++; $display("[TB] FAIL presc_step_%0d: rvalid=%0b rdata=%0d required 1 %0d", j, rvalid_4, rdata_4, j / 2);
            end
            tick;
        end
        arvalid_4 = 1'b0;
        repeat (3) tick;
        awaddr_4 = 32'h0; wdata_4 = 32'h100; wstrb_4 = 4'hF;
        awvalid_4 = 1'b1; wvalid_4 = 1'b1;
        tick;
        awvalid_4 = 1'b0; wvalid_4 = 1'b0;
        arvalid_4 = 1'b1;
        checks++;
        if (bvalid_4 !== 1'b1) begin
            errors++; $display("[TB] FAIL presc_bvalid: got %0b required 1", bvalid_4);
        end
        tick;
        checks++;
        if (rvalid_4 !== 1'b1 || rdata_4 !== 32'h100) begin
            errors++; $display("[TB] FAIL presc_write_wins: rdata=%h required 00000100", rdata_4);
        end
        tick; tick;
        checks++;
        if (rdata_4 !== 32'h100) begin
            errors++; $display("[TB] FAIL presc_restart_a: rdata=%h required 00000100", rdata_4);
        end
        tick; tick;
        checks++;
        if (rdata_4 !== 32'h101) begin
            errors++; $display("[TB] FAIL presc_restart_b: rdata=%h required 00000101", rdata_4);
        end
        arvalid_4 = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        wvalid = 1'b0; bready = 1'b0;
        rst_4 = 1'b1; araddr_4 = 32'h0; arvalid_4 = 1'b0; rready_4 = 1'b0;
        awaddr_4 = 32'h0; awvalid_4 = 1'b0; wdata_4 = 32'h0; wstrb_4 = 4'h0;
        wvalid_4 = 1'b0; bready_4 = 1'b0;
        test_reset;
        test_read_hold;
        test_wrap_shadow;
        test_w_before_aw;
        test_irq;
        test_reset_mid;
        test_prescale4;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_timer.md
AXI_TIMER -- requirements
Module: axi_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, giving clock cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports araddr input 32, arvalid input 1, arready output 1  read address channel.
REQ-005 SHALL have ports rdata output 32, rvalid output 1, rready input 1  read data channel.
REQ-006 SHALL have ports awaddr input 32, awvalid input 1, awready output 1  write address channel.
REQ-007 SHALL have ports wdata input 32, wstrb input 4, wvalid input 1, wready output 1  write data channel.
REQ-008 SHALL have ports bresp output 2, bvalid output 1, bready input 1  write response channel.
REQ-009 SHALL have port timer_irq  output  1  level interrupt, high while mtime >= mtimecmp.

Function
REQ-010 SHALL decode only addr[3:2]: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi; upper bits and addr[1:0] SHALL be ignored.
REQ-011 SHALL hold a 64-bit mtime that increments by 1 every PRESCALE cycles via an internal prescale counter and wraps from all-ones to 0.
REQ-012 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1).
REQ-013 On arvalid&&arready in R_IDLE, the FSM SHALL enter R_DATA next cycle with rdata = selected register value sampled at the accept edge.
REQ-014 In R_DATA, rdata and rvalid SHALL stay stable until rvalid&&rready, then return to R_IDLE; back-to-back reads therefore cost 2 cycles minimum.
REQ-015 Reading mtime_lo SHALL copy mtime[63:32] into a shadow register on the same edge; reading mtime_hi SHALL return the shadow, giving tear-free 64-bit reads.
REQ-016 Write FSM SHALL have states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP; awready=1 in W_IDLE/W_GOT_W, wready=1 in W_IDLE/W_GOT_AW, both 0 in W_RESP.
REQ-017 AW and W SHALL be accepted independently in either order or the same cycle, latching awaddr and wdata/wstrb on their own handshakes.
REQ-018 Once both are held, the register write SHALL occur on the next edge, honouring wstrb per byte, and the FSM SHALL enter W_RESP with bvalid=1, bresp=2'b00.
REQ-019 bvalid SHALL hold until bvalid&&bready, then W_IDLE.
REQ-020 A bus write to mtime on the same edge as an increment SHALL win; the increment is dropped and the prescale counter SHALL restart at 0.
REQ-021 Read and write FSMs SHALL run concurrently; a read accepted on the same edge as a write to the same register SHALL return the pre-write value.
REQ-022 timer_irq SHALL be registered, updating one cycle after mtime or mtimecmp changes.

Reset
REQ-023 On rst high at a clock edge: mtime=0, prescale counter=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, rdata=0, rvalid=0, bvalid=0, bresp=0, timer_irq=0, FSMs idle (arready=awready=wready=1 the following cycle).
REQ-024 Reset mid-transaction SHALL abort it with no response issued and no register written.

Configuration
REQ-025 Macro AXI_TIMER_CMP_EN defined: mtimecmp registers and compare logic SHALL exist as above.
REQ-026 Macro AXI_TIMER_CMP_EN undefined: mtimecmp offsets SHALL read 0, writes to them SHALL be acknowledged with bresp=00 and discarded, timer_irq SHALL be constant 0; port list unchanged.

Verification
REQ-027 PRESCALE=1, release reset, idle 10 cycles, read offset 0x0 -> rdata within 9..11, rvalid held with rready=0 for 3 cycles, data stable.
REQ-028 Write 0xFFFFFFFF to 0x0 and 0x0 to 0x4, wait 5 cycles, read 0x0 then 0x4 -> hi=1, lo small; shadow hi unchanged by further increments before hi read.
REQ-029 Issue W (0x12345678, wstrb=4'b0011) two cycles before AW (0x8), bready=1 -> one bvalid pulse, bresp=00, mtimecmp_lo[15:0]=0x5678, upper bytes keep 0xFFFF.
REQ-030 CMP_EN defined: mtimecmp=20, mtime=0 -> timer_irq rises one cycle after mtime reaches 20; write mtimecmp_hi=1 -> irq falls.
REQ-031 PRESCALE=4: mtime advances exactly once per 4 cycles; write to mtime coinciding with an increment edge -> written value read back exactly.
REQ-032 Assert rst while rvalid=1 and while in W_GOT_AW -> rvalid/bvalid low next cycle, no write, all readies high the following cycle.
